phase_timer: RTL and testbench
==============================

Name: phase_timer

Overview:
- Timing stage directly downstream of the washer controller.
- Consumes the controller's one-hot phase outputs (soak/wash/rinse/spin) and the selected mode, and times each phase.
- Returns a one-cycle phase_Done pulse so the controller can advance its state.
- Also pauses spin while the lid is open, aborts on cancel, and exposes remaining time for display.

Parameters:
- TICKS_PER_UNIT, 1000, clock cycles per time unit (prescaler period, >=1).
- COUNT_W, 16, width of the remaining-time counter.
- SOAK_T, 5, soak base duration in units.
- WASH_T, 10, wash base duration in units.
- RINSE_T, 6, rinse base duration in units.
- SPIN_T, 4, spin base duration in units.

Ports:
- clock  input  1  system clock, rising edge
- reset_n  input  1  asynchronous active-low reset
- soak_Operation  input  1  controller soak phase active
- wash_Operation  input  1  controller wash phase active
- rinse_Operation  input  1  controller rinse phase active
- spin_Operation  input  1  controller spin phase active
- mode_1  input  1  mode select, multiplier 1
- mode_2  input  1  mode select, multiplier 2
- mode_3  input  1  mode select, multiplier 3
- lid  input  1  1 = lid open
- cancel  input  1  abort current timing
- phase_Done  output  1  one-cycle pulse, active phase finished
- time_Remaining  output  COUNT_W  units left in current phase
- paused  output  1  spin timing frozen by open lid
- fault  output  1  more than one phase input asserted

Behaviour:
- Reset (async, reset_n=0): all outputs 0; state T_IDLE; prescaler 0; phase register cleared.
- Phase code: none/soak/wash/rinse/spin, decoded from the four inputs every cycle.
  - Two or more inputs high is illegal: fault=1 that cycle (registered, one-cycle latency); state forced to T_IDLE; time_Remaining=0; no phase_Done.
- Multiplier: sampled only at load. mode_3 > mode_2 > mode_1 priority. No mode bit set gives multiplier 1.
- Duration = base(phase) * multiplier, truncated to COUNT_W bits.
- States:
  - T_IDLE: wait for a legal phase.
  - T_RUN: counting.
  - T_PAUSE: frozen.
  - T_DONE: phase finished, waiting for the controller to move on.
- Load: on any edge where the legal phase code differs from the stored phase code and is non-none:
  - time_Remaining <= duration; prescaler <= 0; state <= T_RUN; store phase code.
  - Applies from any state, including a direct phase-to-phase change with no idle gap.
- T_RUN:
  - Prescaler increments each cycle and wraps at TICKS_PER_UNIT-1; the wrap cycle is a tick.
  - On a tick, time_Remaining decrements.
  - When a tick takes it from 1 to 0, go to T_DONE and assert phase_Done on the next cycle for exactly one cycle.
  - Done edge occurs duration*TICKS_PER_UNIT cycles after the load edge.
- Zero duration (base 0 or truncation): load goes straight to T_DONE; phase_Done pulses the cycle after load.
- Lid pause:
  - If the stored phase is spin and lid=1 in T_RUN: enter T_PAUSE; prescaler and time_Remaining frozen; paused=1.
  - On lid=0: return to T_RUN, resuming at the frozen prescaler value.
  - Lid is ignored for soak/wash/rinse.
- Phase input drops to none:
  - From T_RUN/T_PAUSE/T_DONE: go to T_IDLE; time_Remaining <= 0; paused <= 0; no phase_Done.
- T_DONE: holds time_Remaining=0 until the phase code changes. A new phase reloads; none returns to T_IDLE. Never re-pulses phase_Done.
- cancel=1:
  - Highest priority after reset: state <= T_IDLE; counters cleared; stored phase cleared; phase_Done suppressed, including a pulse that would fire that cycle.
  - While cancel is held, loads are blocked.
  - After release, a still-asserted phase is treated as new and reloads.
- Simultaneous tick-to-zero and phase change on the same edge: load wins; no phase_Done.
- Simultaneous tick and lid open in spin: the tick is applied, then state enters T_PAUSE.

Test Plan:
- Wash, timed by mode:
  - Stimulus: TICKS_PER_UNIT=4, WASH_T=3, mode_2=1; assert wash_Operation at edge E.
  - Response: time_Remaining=6 after E, decrements every 4 cycles, phase_Done high exactly one cycle at E+24, then time_Remaining=0 held in T_DONE.
- Spin pause:
  - Stimulus: SPIN_T=4, mode_1; open lid 5 cycles into spin for 10 cycles.
  - Response: paused=1 for those cycles, time_Remaining frozen at 3; phase_Done at load+16+10.
- Direct phase change:
  - Stimulus: soak running with 2 units left; controller switches directly to rinse (RINSE_T=6, mode_3).
  - Response: no phase_Done; time_Remaining reloads to 18 on the switch edge.
- Cancel:
  - Stimulus: cancel asserted on the same edge the final tick would hit 0.
  - Response: no phase_Done; all outputs 0. After cancel releases with wash still high, the timer reloads to the full duration.
- Illegal phase:
  - Stimulus: wash_Operation and spin_Operation both high for 3 cycles.
  - Response: fault=1 for 3 cycles (one cycle delayed), time_Remaining=0; normal load once only wash remains.
- Async reset:
  - Stimulus: reset_n pulled low mid-phase, between clock edges.
  - Response: all outputs 0 immediately; after release with spin still high, load occurs on the first edge.

Source files
------------

// File: rtl/phase_timer.sv
// phase_timer: times the washer controller's active phase and
// pulses phase_Done when the phase's duration has elapsed.
module phase_timer #(
  parameter int TICKS_PER_UNIT = 1000,
  parameter int COUNT_W        = 16,
  parameter int SOAK_T         = 5,
  parameter int WASH_T         = 10,
  parameter int RINSE_T        = 6,
  parameter int SPIN_T         = 4
) (
  input  logic               clock,
  input  logic               reset_n,
  input  logic               soak_Operation,
  input  logic               wash_Operation,
  input  logic               rinse_Operation,
  input  logic               spin_Operation,
  input  logic               mode_1,
  input  logic               mode_2,
  input  logic               mode_3,
  input  logic               lid,
  input  logic               cancel,
  output logic               phase_Done,
  output logic [COUNT_W-1:0] time_Remaining,
  output logic               paused,
  output logic               fault
);

  localparam int PW =
    (TICKS_PER_UNIT > 1) ? $clog2(TICKS_PER_UNIT) : 1;
  localparam logic [PW-1:0] PRE_MAX =
    PW'(TICKS_PER_UNIT - 1);

  typedef enum logic [1:0] {
    T_IDLE,
    T_RUN,
    T_PAUSE,
    T_DONE
  } state_e;

  typedef enum logic [2:0] {
    PH_NONE,
    PH_SOAK,
    PH_WASH,
    PH_RINSE,
    PH_SPIN
  } phase_e;

  state_e             state_q, state_d;
  phase_e             phase_q, phase_d;
  phase_e             code;
  logic [PW-1:0]      pre_q, pre_d;
  logic [COUNT_W-1:0] cnt_q, cnt_d;
  logic               done_q, done_d;
  logic               paused_q, paused_d;
  logic               fault_q, fault_d;
  logic [3:0]         ops;
  logic               illegal;
  logic               load;
  logic               tick;
  int unsigned        base;
  int unsigned        mult;
  logic [COUNT_W-1:0] dur;

  assign ops = {soak_Operation, wash_Operation,
                rinse_Operation, spin_Operation};
  // Clearing the lowest set bit leaves something only if 2+ are set.
  assign illegal = |(ops & (ops - 4'd1));

  always_comb begin
    code = PH_NONE;
    if (!illegal) begin
      unique case (1'b1)
        soak_Operation:  code = PH_SOAK;
        wash_Operation:  code = PH_WASH;
        rinse_Operation: code = PH_RINSE;
        spin_Operation:  code = PH_SPIN;
        default:         code = PH_NONE;
      endcase
    end
  end

  always_comb begin
    base = 0;
    unique case (code)
      PH_SOAK:  base = SOAK_T;
      PH_WASH:  base = WASH_T;
      PH_RINSE: base = RINSE_T;
      PH_SPIN:  base = SPIN_T;
      default:  base = 0;
    endcase
  end

  always_comb begin
    mult = 1;
    if (mode_3) begin
      mult = 3;
    end else if (mode_2) begin
      mult = 2;
    end
  end

  assign dur  = COUNT_W'(base * mult);
  assign tick = (pre_q == PRE_MAX);
  assign load = !cancel && !illegal
             && (code != PH_NONE) && (code != phase_q);

  always_comb begin
    state_d = state_q;
    phase_d = phase_q;
    pre_d   = pre_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;
    fault_d = illegal && !cancel;
    if (cancel || illegal) begin
      state_d = T_IDLE;
      phase_d = PH_NONE;
      pre_d   = '0;
      cnt_d   = '0;
    end else if (load) begin
      phase_d = code;
      pre_d   = '0;
      cnt_d   = dur;
      if (dur == '0) begin
        state_d = T_DONE;
        done_d  = 1'b1;
      end else begin
        state_d = T_RUN;
      end
    end else if (code == PH_NONE) begin
      state_d = T_IDLE;
      phase_d = PH_NONE;
      pre_d   = '0;
      cnt_d   = '0;
    end else begin
      unique case (state_q)
        T_RUN: begin
          pre_d = tick ? '0 : pre_q + PW'(1);
          if (tick) begin
            cnt_d = cnt_q - COUNT_W'(1);
          end
          // Reaching zero takes precedence over a lid pause.
          if (tick && cnt_q == COUNT_W'(1)) begin
            state_d = T_DONE;
            done_d  = 1'b1;
          end else if (phase_q == PH_SPIN && lid) begin
            state_d = T_PAUSE;
          end
        end
        T_PAUSE: begin
          if (!lid) begin
            state_d = T_RUN;
          end
        end
        default: begin
        end
      endcase
    end
    paused_d = (state_d == T_PAUSE);
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= T_IDLE;
      phase_q  <= PH_NONE;
      pre_q    <= '0;
      cnt_q    <= '0;
      done_q   <= 1'b0;
      paused_q <= 1'b0;
      fault_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      phase_q  <= phase_d;
      pre_q    <= pre_d;
      cnt_q    <= cnt_d;
      done_q   <= done_d;
      paused_q <= paused_d;
      fault_q  <= fault_d;
    end
  end

  // Cancel also masks a pulse already sitting in the output register.
  assign phase_Done     = done_q && !cancel;
  assign time_Remaining = cnt_q;
  assign paused         = paused_q;
  assign fault          = fault_q;

endmodule

// File: tb/tb_phase_timer.sv
// tb_phase_timer: directed scenarios plus a randomized run
// against a cycle-count reference model of phase timing.
module tb_phase_timer;

  localparam int TPU   = 4;
  localparam int CW    = 5;
  localparam int SOAK  = 16;
  localparam int WASH  = 3;
  localparam int RINSE = 6;
  localparam int SPIN  = 4;

  logic          clock = 1'b0;
  logic          reset_n = 1'b0;
  logic          soak_Operation = 1'b0;
  logic          wash_Operation = 1'b0;
  logic          rinse_Operation = 1'b0;
  logic          spin_Operation = 1'b0;
  logic          mode_1 = 1'b0;
  logic          mode_2 = 1'b0;
  logic          mode_3 = 1'b0;
  logic          lid = 1'b0;
  logic          cancel = 1'b0;
  logic          phase_Done;
  logic [CW-1:0] time_Remaining;
  logic          paused;
  logic          fault;

  int checks = 0;
  int errors = 0;

  phase_timer #(
    .TICKS_PER_UNIT(TPU),
    .COUNT_W(CW),
    .SOAK_T(SOAK),
    .WASH_T(WASH),
    .RINSE_T(RINSE),
    .SPIN_T(SPIN)
  ) dut (
    .clock(clock),
    .reset_n(reset_n),
    .soak_Operation(soak_Operation),
    .wash_Operation(wash_Operation),
    .rinse_Operation(rinse_Operation),
    .spin_Operation(spin_Operation),
    .mode_1(mode_1),
    .mode_2(mode_2),
    .mode_3(mode_3),
    .lid(lid),
    .cancel(cancel),
    .phase_Done(phase_Done),
    .time_Remaining(time_Remaining),
    .paused(paused),
    .fault(fault)
  );

  always #5 clock = ~clock;

  // Reference model: phase number (0 none, 1..4), activity
  // (0 idle, 1 counting, 2 frozen, 3 finished), counted cycles.
  int m_ph, m_act, m_dur, m_el;
  bit m_done, m_fault;

  function automatic int m_rem();
    if (m_act == 1 || m_act == 2) return m_dur - m_el / TPU;
    return 0;
  endfunction

  function automatic void model_step();
    int n, code, mult, b;
    n = int'(soak_Operation) + int'(wash_Operation)
      + int'(rinse_Operation) + int'(spin_Operation);
    code = 0;
    if (n == 1) begin
      if (soak_Operation) code = 1;
      else if (wash_Operation) code = 2;
      else if (rinse_Operation) code = 3;
      else code = 4;
    end
    mult = mode_3 ? 3 : (mode_2 ? 2 : 1);
    b = (code == 1) ? SOAK : (code == 2) ? WASH
      : (code == 3) ? RINSE : SPIN;
    m_done = 0;
    m_fault = (n > 1) && !cancel;
    if (cancel || n > 1 || code == 0) begin
      m_ph = 0; m_act = 0; m_el = 0; m_dur = 0;
    end else if (code != m_ph) begin
      m_ph = code;
      m_dur = (b * mult) % (1 << CW);
      m_el = 0;
      if (m_dur == 0) begin m_act = 3; m_done = 1; end
      else m_act = 1;
    end else if (m_act == 1) begin
      m_el++;
      if (m_el == m_dur * TPU) begin m_act = 3; m_done = 1; end
      else if (m_ph == 4 && lid) m_act = 2;
    end else if (m_act == 2 && !lid) begin
      m_act = 1;
    end
  endfunction

  task automatic clear_inputs();
    soak_Operation = 0; wash_Operation = 0;
    rinse_Operation = 0; spin_Operation = 0;
    mode_1 = 0; mode_2 = 0; mode_3 = 0;
    lid = 0; cancel = 0;
  endtask

  task automatic do_reset();
    clear_inputs();
    reset_n = 0;
    repeat (2) @(negedge clock);
    reset_n = 1;
  endtask

  task automatic test_reset();
    reset_n = 0;
    clear_inputs();
    wash_Operation = 1;
    repeat (2) @(negedge clock);
    checks++;
    if ({phase_Done, time_Remaining, paused, fault} !== '0) begin
      errors++;
      $display("FAIL reset_outputs got %b want 0",
        {phase_Done, time_Remaining, paused, fault});
    end
    reset_n = 1;
    @(negedge clock);
    checks++;
    if (time_Remaining !== CW'(3)) begin
      errors++;
      $display("FAIL reset_release_load got %0d want 3",
        time_Remaining);
    end
  endtask

  task automatic test_wash_timing();
    int exp_rem;
    do_reset();
    wash_Operation = 1; mode_2 = 1;
    @(negedge clock);
    checks++;
    if (time_Remaining !== CW'(6)) begin
      errors++;
      $display("FAIL wash_load got %0d want 6", time_Remaining);
    end
    for (int i = 1; i <= 28; i++) begin
      @(negedge clock);
      exp_rem = (i >= 24) ? 0 : 6 - i / 4;
      checks++;
      if (time_Remaining !== CW'(exp_rem)) begin
        errors++;
        $display("FAIL wash_rem i=%0d got %0d want %0d",
          i, time_Remaining, exp_rem);
      end
      checks++;
      if (phase_Done !== (i == 24)) begin
        errors++;
        $display("FAIL wash_done i=%0d got %b want %b",
          i, phase_Done, (i == 24));
      end
    end
  endtask

  task automatic test_spin_pause();
    int c, exp_rem;
    bit lo;
    do_reset();
    spin_Operation = 1; mode_1 = 1;
    @(negedge clock);
    checks++;
    if (time_Remaining !== CW'(4)) begin
      errors++;
      $display("FAIL spin_load got %0d want 4", time_Remaining);
    end
    for (int i = 1; i <= 30; i++) begin
      lo = (i >= 5 && i <= 14);
      lid = lo;
      @(negedge clock);
      c = (i <= 5) ? i : (i <= 15) ? 5 : i - 10;
      exp_rem = (i >= 26) ? 0 : 4 - c / 4;
      checks++;
      if (paused !== lo) begin
        errors++;
        $display("FAIL spin_paused i=%0d got %b want %b",
          i, paused, lo);
      end
      checks++;
      if (time_Remaining !== CW'(exp_rem)) begin
        errors++;
        $display("FAIL spin_rem i=%0d got %0d want %0d",
          i, time_Remaining, exp_rem);
      end
      checks++;
      if (phase_Done !== (i == 26)) begin
        errors++;
        $display("FAIL spin_done i=%0d got %b want %b",
          i, phase_Done, (i == 26));
      end
    end
  endtask

  task automatic test_direct_change();
    do_reset();
    soak_Operation = 1; mode_1 = 1;
    repeat (58) @(negedge clock);
    checks++;
    if (time_Remaining !== CW'(2)) begin
      errors++;
      $display("FAIL soak_two_left got %0d want 2", time_Remaining);
    end
    soak_Operation = 0; rinse_Operation = 1;
    mode_1 = 0; mode_3 = 1;
    @(negedge clock);
    checks++;
    if (time_Remaining !== CW'(18) || phase_Done !== 1'b0) begin
      errors++;
      $display("FAIL rinse_switch got %0d/%b want 18/0",
        time_Remaining, phase_Done);
    end
    repeat (71) @(negedge clock);
    checks++;
    if (time_Remaining !== CW'(1)) begin
      errors++;
      $display("FAIL rinse_last got %0d want 1", time_Remaining);
    end
    rinse_Operation = 0; wash_Operation = 1;
    mode_3 = 0; mode_1 = 1;
    @(negedge clock);
    checks++;
    if (time_Remaining !== CW'(3) || phase_Done !== 1'b0) begin
      errors++;
      $display("FAIL load_beats_done got %0d/%b want 3/0",
        time_Remaining, phase_Done);
    end
  endtask

  task automatic test_cancel();
    do_reset();
    wash_Operation = 1; mode_1 = 1;
    repeat (12) @(negedge clock);
    cancel = 1;
    @(negedge clock);
    checks++;
    if ({phase_Done, time_Remaining, paused, fault} !== '0) begin
      errors++;
      $display("FAIL cancel_final_tick got %b want 0",
        {phase_Done, time_Remaining, paused, fault});
    end
    @(negedge clock);
    checks++;
    if (time_Remaining !== '0) begin
      errors++;
      $display("FAIL cancel_blocks_load got %0d want 0",
        time_Remaining);
    end
    cancel = 0;
    @(negedge clock);
    checks++;
    if (time_Remaining !== CW'(3)) begin
      errors++;
      $display("FAIL cancel_reload got %0d want 3", time_Remaining);
    end
    repeat (12) @(negedge clock);
    checks++;
    if (phase_Done !== 1'b1) begin
      errors++;
      $display("FAIL cancel_redone got %b want 1", phase_Done);
    end
    cancel = 1;
    #1;
    checks++;
    if (phase_Done !== 1'b0) begin
      errors++;
      $display("FAIL cancel_masks_pulse got %b want 0", phase_Done);
    end
    @(negedge clock);
    cancel = 0;
  endtask

  task automatic test_illegal();
    do_reset();
    wash_Operation = 1; spin_Operation = 1; mode_1 = 1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      checks++;
      if (fault !== 1'b1 || time_Remaining !== '0
          || phase_Done !== 1'b0) begin
        errors++;
        $display("FAIL illegal_fault i=%0d got %b/%0d/%b want 1/0/0",
          i, fault, time_Remaining, phase_Done);
      end
    end
    spin_Operation = 0;
    @(negedge clock);
    checks++;
    if (fault !== 1'b0 || time_Remaining !== CW'(3)) begin
      errors++;
      $display("FAIL illegal_recover got %b/%0d want 0/3",
        fault, time_Remaining);
    end
  endtask

  task automatic test_zero_duration();
    do_reset();
    soak_Operation = 1; mode_2 = 1;
    @(negedge clock);
    checks++;
    if (phase_Done !== 1'b1 || time_Remaining !== '0) begin
      errors++;
      $display("FAIL zero_pulse got %b/%0d want 1/0",
        phase_Done, time_Remaining);
    end
    for (int i = 0; i < 4; i++) begin
      @(negedge clock);
      checks++;
      if (phase_Done !== 1'b0) begin
        errors++;
        $display("FAIL zero_no_repulse i=%0d got %b want 0",
          i, phase_Done);
      end
    end
    soak_Operation = 0; wash_Operation = 1;
    @(negedge clock);
    checks++;
    if (time_Remaining !== CW'(6)) begin
      errors++;
      $display("FAIL done_to_wash got %0d want 6", time_Remaining);
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    spin_Operation = 1; mode_2 = 1;
    repeat (3) @(negedge clock);
    lid = 1;
    repeat (2) @(negedge clock);
    checks++;
    if (paused !== 1'b1 || time_Remaining !== CW'(8)) begin
      errors++;
      $display("FAIL async_pre got %b/%0d want 1/8",
        paused, time_Remaining);
    end
    @(posedge clock);
    #2;
    reset_n = 0;
    #1;
    checks++;
    if ({phase_Done, time_Remaining, paused, fault} !== '0) begin
      errors++;
      $display("FAIL async_clear got %b want 0",
        {phase_Done, time_Remaining, paused, fault});
    end
    @(negedge clock);
    lid = 0;
    reset_n = 1;
    @(negedge clock);
    checks++;
    if (time_Remaining !== CW'(8)) begin
      errors++;
      $display("FAIL async_reload got %0d want 8", time_Remaining);
    end
  endtask

  task automatic test_random();
    int r, p;
    do_reset();
    m_ph = 0; m_act = 0; m_dur = 0; m_el = 0;
    m_done = 0; m_fault = 0;
    for (int cyc = 0; cyc < 4000; cyc++) begin
      r = $urandom_range(0, 99);
      if (r < 3) begin
        p = $urandom_range(0, 4);
        soak_Operation  = (p == 1);
        wash_Operation  = (p == 2);
        rinse_Operation = (p == 3);
        spin_Operation  = (p == 4);
      end else if (r < 4) begin
        p = $urandom_range(0, 3);
        soak_Operation  = 1;
        wash_Operation  = (p != 0);
        rinse_Operation = (p == 2);
        spin_Operation  = (p == 3);
      end
      if (r < 12) begin
        mode_1 = 1'($urandom); mode_2 = 1'($urandom);
        mode_3 = 1'($urandom);
      end
      cancel = ($urandom_range(0, 69) == 0);
      if ($urandom_range(0, 7) == 0) lid = ~lid;
      @(posedge clock);
      model_step();
      @(negedge clock);
      checks++;
      if (time_Remaining !== CW'(m_rem())) begin
        errors++;
        $display("FAIL rnd_rem cyc=%0d got %0d want %0d",
          cyc, time_Remaining, m_rem());
      end
      checks++;
      if (phase_Done !== (m_done && !cancel)) begin
        errors++;
        $display("FAIL rnd_done cyc=%0d got %b want %b",
          cyc, phase_Done, m_done && !cancel);
      end
      checks++;
      if (paused !== (m_act == 2)) begin
        errors++;
        $display("FAIL rnd_paused cyc=%0d got %b want %b",
          cyc, paused, m_act == 2);
      end
      checks++;
      if (fault !== m_fault) begin
        errors++;
        $display("FAIL rnd_fault cyc=%0d got %b want %b",
          cyc, fault, m_fault);
      end
    end
  endtask

  initial begin
    test_reset();
    test_wash_timing();
    test_spin_pause();
    test_direct_change();
    test_cancel();
    test_illegal();
    test_zero_duration();
    test_async_reset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
